control_multiciclo: RTL and testbench

Multicycle control unit for the RV32I core that sequences one shared instruction/data memory, the ALU, and the register file over several clock cycles per instruction. It replaces the single-cycle decoder and PC-select logic when the datapath gains IR, MDR, ALUOut and OldPC registers. It is a Moore FSM whose memory-state and branch enables are gated by the memory ready handshake and ALU zero flag.

---
 rtl/control_multiciclo.sv | 190 +++++++++++++++++++
 tb/tb_control_multiciclo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back over a shared memory.
// Latency: CPI 3..5 plus one cycle per low mem_ready_i in FETCH, MEM_RD or MEM_WR; enables are held until ready.
module control_multiciclo #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [6:0]           opcode_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 pcwrite_o,
    output logic                 irwrite_o,
    output logic                 iord_o,
    output logic                 memread_o,
    output logic                 memwrite_o,
    output logic                 regwrite_o,
    output logic [1:0]           wbsel_o,
    output logic [1:0]           alusrca_o,
    output logic [1:0]           alusrcb_o,
    output logic [1:0]           aluop_o,
    output logic                 pcsource_o,
    output logic [3:0]           state_o,
    output logic                 illegal_o,
    output logic [INSTRET_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t                state;
    logic                  illegal;
    logic [INSTRET_W-1:0]  instret;
    logic                  pcwrite_raw;
    logic                  irwrite_raw;
    logic                  memread_raw;
    logic                  memwrite_raw;
    logic                  regwrite_raw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready_i) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode_i)
                        OP_R:               state <= S_EXEC_R;
                        OP_I:               state <= S_EXEC_I;
                        OP_LOAD, OP_STORE:  state <= S_MEM_ADDR;
                        OP_BRANCH:          state <= S_BRANCH;
                        OP_JAL:             state <= S_JAL;
                        OP_JALR:            state <= S_JALR;
                        default: begin
                            state   <= S_TRAP;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= S_ALU_WB;
                // opcode is already known to be a load or a store here
                S_MEM_ADDR: state <= (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready_i) state <= S_MEM_WB;
                S_MEM_WR: begin
                    if (mem_ready_i) begin
                        state   <= S_FETCH;
                        instret <= instret + INSTRET_ONE;
                    end
                end
                S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: begin
                    state   <= S_FETCH;
                    instret <= instret + INSTRET_ONE;
                end
                S_TRAP: state <= S_TRAP;
                default: begin
                    state   <= S_TRAP;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memread_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        iord_o       = 1'b0;
        wbsel_o      = 2'd0;
        alusrca_o    = 2'd0;
        alusrcb_o    = 2'd0;
        aluop_o      = 2'd0;
        pcsource_o   = 1'b0;
        case (state)
            S_FETCH: begin
                memread_raw = 1'b1;
                alusrcb_o   = 2'd1;
                irwrite_raw = mem_ready_i;
                pcwrite_raw = mem_ready_i;
            end
            S_DECODE: begin
                alusrca_o = 2'd2;
                alusrcb_o = 2'd2;
            end
            S_EXEC_R: begin
                alusrca_o = 2'd1;
                aluop_o   = 2'd2;
            end
            S_EXEC_I: begin
                alusrca_o = 2'd1;
                alusrcb_o = 2'd2;
                aluop_o   = 2'd3;
            end
            S_MEM_ADDR: begin
                alusrca_o = 2'd1;
                alusrcb_o = 2'd2;
            end
            S_MEM_RD: begin
                memread_raw = 1'b1;
                iord_o      = 1'b1;
            end
            S_MEM_WB: begin
                regwrite_raw = 1'b1;
                wbsel_o      = 2'd1;
            end
            S_MEM_WR: begin
                memwrite_raw = 1'b1;
                iord_o       = 1'b1;
            end
            S_ALU_WB: regwrite_raw = 1'b1;
            S_BRANCH: begin
                alusrca_o   = 2'd1;
                aluop_o     = 2'd1;
                pcsource_o  = 1'b1;
                pcwrite_raw = zero_i;
            end
            S_JAL: begin
                regwrite_raw = 1'b1;
                wbsel_o      = 2'd2;
                pcwrite_raw  = 1'b1;
                pcsource_o   = 1'b1;
            end
            // rd takes the PC still held before this edge, i.e. OldPC+4
            S_JALR: begin
                alusrca_o    = 2'd1;
                alusrcb_o    = 2'd2;
                pcwrite_raw  = 1'b1;
                regwrite_raw = 1'b1;
                wbsel_o      = 2'd2;
            end
            default: ;
        endcase
    end

    // Reset must silence every write strobe even though state already reads FETCH
    assign pcwrite_o  = pcwrite_raw  & rst_ni;
    assign irwrite_o  = irwrite_raw  & rst_ni;
    assign memread_o  = memread_raw  & rst_ni;
    assign memwrite_o = memwrite_raw & rst_ni;
    assign regwrite_o = regwrite_raw & rst_ni;
    assign state_o    = state;
    assign illegal_o  = illegal;
    assign instret_o  = instret;

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: driver queues hand-computed per-cycle vectors, monitor compares at negedge.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       rdy;
    logic       pcwrite, irwrite, iord, memread, memwrite, regwrite, pcsource, illegal;
    logic [1:0] wbsel, alusrca, alusrcb, aluop;
    logic [3:0] state;
    logic [3:0] instret;

    control_multiciclo #(.INSTRET_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(op), .zero_i(zero), .mem_ready_i(rdy),
        .pcwrite_o(pcwrite), .irwrite_o(irwrite), .iord_o(iord), .memread_o(memread),
        .memwrite_o(memwrite), .regwrite_o(regwrite), .wbsel_o(wbsel), .alusrca_o(alusrca),
        .alusrcb_o(alusrcb), .aluop_o(aluop), .pcsource_o(pcsource), .state_o(state),
        .illegal_o(illegal), .instret_o(instret)
    );

    always #5 clk = ~clk;

    // en = {pcwrite, irwrite, iord, memread, memwrite, regwrite}
    typedef struct packed {
        logic [3:0] st;
        logic [5:0] en;
        logic [1:0] wb;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] ao;
        logic       ps;
        logic       il;
        logic [3:0] ir;
    } vec_t;

    localparam logic [5:0] EN_0   = 6'b000000;
    localparam logic [5:0] EN_F   = 6'b110100;
    localparam logic [5:0] EN_FW  = 6'b000100;
    localparam logic [5:0] EN_MR  = 6'b001100;
    localparam logic [5:0] EN_MW  = 6'b001010;
    localparam logic [5:0] EN_RW  = 6'b000001;
    localparam logic [5:0] EN_PW  = 6'b100000;
    localparam logic [5:0] EN_JMP = 6'b100001;

    vec_t exp_q[$];
    int   id_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e, a;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = {state, pcwrite, irwrite, iord, memread, memwrite, regwrite,
                  wbsel, alusrca, alusrcb, aluop, pcsource, illegal, instret};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step %0d: got st=%0d en=%b wb=%0d sa=%0d sb=%0d ao=%0d ps=%b il=%b ir=%0d, want st=%0d en=%b wb=%0d sa=%0d sb=%0d ao=%0d ps=%b il=%b ir=%0d",
                         id, a.st, a.en, a.wb, a.sa, a.sb, a.ao, a.ps, a.il, a.ir,
                         e.st, e.en, e.wb, e.sa, e.sb, e.ao, e.ps, e.il, e.ir);
            end
        end
    end

    // Applies inputs for the current cycle, queues its expected outputs, then advances one edge.
    task automatic step(input logic r, input logic z, input logic [3:0] st, input logic [5:0] en,
                        input logic [1:0] wb, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] ao, input logic ps, input logic il, input logic [3:0] ir);
        vec_t v;
        rdy  = r;
        zero = z;
        v = '{st: st, en: en, wb: wb, sa: sa, sb: sb, ao: ao, ps: ps, il: il, ir: ir};
        exp_q.push_back(v);
        id_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch(input logic r, input logic [3:0] ir);
        step(r, 1'b0, 4'd0, r ? EN_F : EN_FW, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, ir);
    endtask

    task automatic t_decode(input logic [6:0] opc, input logic [3:0] ir);
        op = opc;
        step(1'b1, 1'b0, 4'd1, EN_0, 2'd0, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, ir);
    endtask

    task automatic t_reset(input logic il);
        step(1'b0, 1'b0, 4'd0, EN_0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, il, 4'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not end, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        op    = 7'd0;
        zero  = 1'b0;
        rdy   = 1'b1;
        @(posedge clk);
        #1;
        t_reset(1'b0);             // FETCH selects, no strobes, counters cleared
        rst_n = 1'b1;

        // add: 0,1,2,8 then retire
        t_fetch(1'b1, 4'd0);
        t_decode(7'b0110011, 4'd0);
        step(1'b1, 1'b0, 4'd2, EN_0, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd8, EN_RW, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0);

        // load with two wait cycles in MEM_RD: 7 cycles
        t_fetch(1'b1, 4'd1);
        t_decode(7'b0000011, 4'd1);
        step(1'b1, 1'b0, 4'd4, EN_0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 4'd5, EN_MR, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 4'd5, EN_MR, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 4'd5, EN_MR, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 1'b0, 4'd6, EN_RW, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd1);

        // beq taken then not taken
        t_fetch(1'b1, 4'd2);
        t_decode(7'b1100011, 4'd2);
        step(1'b1, 1'b1, 4'd9, EN_PW, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0, 4'd2);
        t_fetch(1'b1, 4'd3);
        t_decode(7'b1100011, 4'd3);
        step(1'b1, 1'b0, 4'd9, EN_0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0, 4'd3);

        // JAL then JALR
        t_fetch(1'b1, 4'd4);
        t_decode(7'b1101111, 4'd4);
        step(1'b1, 1'b0, 4'd10, EN_JMP, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd4);
        t_fetch(1'b1, 4'd5);
        t_decode(7'b1100111, 4'd5);
        step(1'b1, 1'b0, 4'd11, EN_JMP, 2'd2, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'd5);

        // store with a FETCH wait and a MEM_WR wait
        t_fetch(1'b0, 4'd6);
        t_fetch(1'b1, 4'd6);
        t_decode(7'b0100011, 4'd6);
        step(1'b1, 1'b0, 4'd4, EN_0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'd6);
        step(1'b0, 1'b0, 4'd7, EN_MW, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd6);
        step(1'b1, 1'b0, 4'd7, EN_MW, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd6);

        // I-type
        t_fetch(1'b1, 4'd7);
        t_decode(7'b0010011, 4'd7);
        step(1'b1, 1'b0, 4'd3, EN_0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 4'd7);
        step(1'b1, 1'b0, 4'd8, EN_RW, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd7);

        // reset asserted while MEM_WR waits: strobes drop without an edge
        t_fetch(1'b1, 4'd8);
        t_decode(7'b0100011, 4'd8);
        step(1'b1, 1'b0, 4'd4, EN_0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'd8);
        step(1'b0, 1'b0, 4'd7, EN_MW, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd8);
        rst_n = 1'b0;
        t_reset(1'b0);
        rst_n = 1'b1;

        // illegal opcode: sticky TRAP with no enables despite ready/zero high
        t_fetch(1'b1, 4'd0);
        t_decode(7'b0000000, 4'd0);
        for (int i = 0; i < 11; i++)
            step(1'b1, 1'b1, 4'd15, EN_0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'd0);
        rst_n = 1'b0;
        t_reset(1'b0);
        rst_n = 1'b1;

        // 16 retirements wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            logic [3:0] n;
            n = i[3:0];
            t_fetch(1'b1, n);
            t_decode(7'b1101111, n);
            step(1'b1, 1'b0, 4'd10, EN_JMP, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, n);
        end
        t_fetch(1'b1, 4'd0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
